visaccum: RTL

//  Sits directly downstream of the correlator daisy-chain merge stage. Integrates the

---
 rtl/visaccum.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/visaccum.sv
`default_nettype none
// ============================================================================
//  Module      : visaccum
//  Description : Ping-pong visibility integrator. Sums LENGTH-value frames
//                over COUNT frames into one bank while the other bank drains
//                on a valid/ready stream. A block that completes while the
//                previous one is still draining is dropped (sticky overflow).
//  Revision    : 1.0  initial release
// ============================================================================
module visaccum #(
    parameter int LENGTH = 3,
    parameter int WIDTH  = 7,
    parameter int ACCUM  = 24,
    parameter int COUNT  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    seq_valid_i,
    input  logic signed [WIDTH-1:0] seq_rdata_i,
    input  logic signed [WIDTH-1:0] seq_idata_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    m_last_o,
    output logic [ACCUM-1:0]        m_rdata_o,
    output logic [ACCUM-1:0]        m_idata_o,
    output logic                    overflow_o
);

    localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int FRM_W = (COUNT > 1) ? $clog2(COUNT) : 1;

    // Reject parameter sets where the accumulator could wrap in legal use
    generate
        if (ACCUM < WIDTH + $clog2(COUNT)) begin : g_bad_accum
            $error("visaccum: ACCUM must be >= WIDTH + clog2(COUNT)");
        end
        if (COUNT < 1) begin : g_bad_count
            $error("visaccum: COUNT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_LOAD = 2'd1,
        RD_SEND = 2'd2
    } rd_state_e;

    rd_state_e          state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [FRM_W-1:0]   frame_q;
    logic               wb_q;
    logic               overflow_q;
    logic               rb_q;
    logic [IDX_W-1:0]   ridx_q;
    logic [ACCUM-1:0]   rdata_q;
    logic [ACCUM-1:0]   idata_q;
    logic               last_q;

    // Bank storage: [bank][index]; contents need no reset
    logic [ACCUM-1:0]   bank_r_q [2][LENGTH];
    logic [ACCUM-1:0]   bank_i_q [2][LENGTH];

    logic [ACCUM-1:0]   in_r_ext;
    logic [ACCUM-1:0]   in_i_ext;
    logic               idx_last;
    logic               frame_last;
    logic               complete;
    logic               rd_idle;
    logic               ridx_last;

    assign in_r_ext   = ACCUM'(seq_rdata_i);
    assign in_i_ext   = ACCUM'(seq_idata_i);
    assign idx_last   = (idx_q == IDX_W'(LENGTH - 1));
    assign frame_last = (frame_q == FRM_W'(COUNT - 1));
    assign complete   = seq_valid_i && idx_last && frame_last;
    assign rd_idle    = (state_q == RD_IDLE);
    assign ridx_last  = (ridx_q == IDX_W'(LENGTH - 1));

    // Write-side position counters, bank select and sticky drop flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            frame_q    <= '0;
            wb_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else if (seq_valid_i) begin
            if (idx_last) begin
                idx_q <= '0;
                if (frame_last) begin
                    frame_q <= '0;
                    // Busy reader: keep wb so the next block overwrites the dropped one
                    if (rd_idle) begin
                        wb_q <= ~wb_q;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end else begin
                    frame_q <= frame_q + FRM_W'(1);
                end
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    // Integrate into the write bank; frame 0 overwrites stale contents
    always_ff @(posedge clock) begin
        if (seq_valid_i) begin
            if (frame_q == '0) begin
                bank_r_q[wb_q][idx_q] <= in_r_ext;
                bank_i_q[wb_q][idx_q] <= in_i_ext;
            end else begin
                bank_r_q[wb_q][idx_q] <= bank_r_q[wb_q][idx_q] + in_r_ext;
                bank_i_q[wb_q][idx_q] <= bank_i_q[wb_q][idx_q] + in_i_ext;
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM next-state: IDLE -> LOAD -> SEND -> (LOAD | IDLE)
    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: if (complete) state_d = RD_LOAD;
            RD_LOAD: state_d = RD_SEND;
            RD_SEND: if (m_ready_i) state_d = ridx_last ? RD_IDLE : RD_LOAD;
            default: state_d = RD_IDLE;
        endcase
    end

    // Read datapath: capture bank select, fetch in LOAD, hold while stalled in SEND
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rb_q    <= 1'b0;
            ridx_q  <= '0;
            rdata_q <= '0;
            idata_q <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (complete) begin
                        rb_q   <= wb_q;
                        ridx_q <= '0;
                    end
                end
                RD_LOAD: begin
                    rdata_q <= bank_r_q[rb_q][ridx_q];
                    idata_q <= bank_i_q[rb_q][ridx_q];
                    last_q  <= ridx_last;
                end
                RD_SEND: begin
                    if (m_ready_i) begin
                        ridx_q <= ridx_last ? '0 : ridx_q + IDX_W'(1);
                    end
                end
                default: begin
                    ridx_q <= '0;
                end
            endcase
        end
    end

    assign m_valid_o  = (state_q == RD_SEND);
    assign m_last_o   = last_q && m_valid_o;
    assign m_rdata_o  = rdata_q;
    assign m_idata_o  = idata_q;
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire
